// File: rtl/tnoc_output_arbiter.sv
// Packet-granular round-robin arbiter for one router output port.
// The grant is held until the owner's tail flit is accepted downstream.

// One lane per requester: wins when it requests and no requester ahead of it
// in the rotated order (starting at ptr) is requesting.
module tnoc_output_arbiter_lane #(
  parameter int REQUESTS = 5,
  parameter int INDEX    = 0,
  parameter int IDX_W    = $clog2(REQUESTS)
)(
  input  logic [REQUESTS-1:0] eff_req,
  input  logic [IDX_W-1:0]    ptr,
  output logic                win
);
  localparam logic [IDX_W-1:0] SELF = IDX_W'(INDEX);

  logic blocked;
  logic ahead;

  always_comb begin
    blocked = 1'b0;
    ahead   = 1'b0;
    for (int j = 0; j < REQUESTS; j++) begin
      // j precedes SELF when it lies in the cyclic range [ptr, SELF)
      if (SELF >= ptr) ahead = (IDX_W'(j) >= ptr) && (IDX_W'(j) < SELF);
      else             ahead = (IDX_W'(j) >= ptr) || (IDX_W'(j) < SELF);
      if (ahead && eff_req[j]) blocked = 1'b1;
    end
  end

  assign win = eff_req[INDEX] && !blocked;
endmodule

module tnoc_output_arbiter #(
  parameter int                  REQUESTS     = 5,
  parameter logic [REQUESTS-1:0] REQUEST_MASK = '1
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQUESTS-1:0]           i_request,
  input  logic                          i_output_available,
  input  logic                          i_free,
  output logic [REQUESTS-1:0]           o_grant,
  output logic [$clog2(REQUESTS)-1:0]   o_grant_index,
  output logic                          o_busy,
  output logic                          o_protocol_error
);
  localparam int IDX_W = $clog2(REQUESTS);

  typedef enum logic { IDLE, GRANTED } state_t;

  typedef struct packed {
    logic [REQUESTS-1:0] grant;
    logic [IDX_W-1:0]    index;
  } arb_t;

  state_t              state_q, state_d;
  arb_t                cur_q, cur_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                perr_q, perr_d;

  logic [REQUESTS-1:0] eff_req;
  logic [REQUESTS-1:0] win;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    ptr_inc;
  logic [IDX_W-1:0]    arb_ptr;
  logic                any_req;

  assign eff_req = i_request & REQUEST_MASK;
  assign any_req = |eff_req;
  assign ptr_inc = (cur_q.index == IDX_W'(REQUESTS - 1)) ? '0 : cur_q.index + 1'b1;
  // While granted, arbitration only matters on i_free, and then the released
  // owner must already be lowest priority.
  assign arb_ptr = (state_q == GRANTED) ? ptr_inc : ptr_q;

  for (genvar i = 0; i < REQUESTS; i++) begin : g_lane
    tnoc_output_arbiter_lane #(
      .REQUESTS (REQUESTS),
      .INDEX    (i),
      .IDX_W    (IDX_W)
    ) u_lane (
      .eff_req (eff_req),
      .ptr     (arb_ptr),
      .win     (win[i])
    );
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < REQUESTS; i++)
      if (win[i]) win_idx = IDX_W'(i);
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (i_free) perr_d = 1'b1;
        if (any_req && i_output_available) begin
          cur_d.grant = win;
          cur_d.index = win_idx;
          state_d     = GRANTED;
        end else begin
          cur_d.grant = '0;
        end
      end
      GRANTED: begin
        if (i_free) begin
          ptr_d = ptr_inc;
          if (any_req && i_output_available) begin
            cur_d.grant = win;
            cur_d.index = win_idx;
          end else begin
            cur_d.grant = '0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      ptr_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      perr_q  <= perr_d;
    end
  end

  assign o_grant          = cur_q.grant;
  assign o_grant_index    = cur_q.index;
  assign o_busy           = (state_q == GRANTED);
  assign o_protocol_error = perr_q;
endmodule

// File: tb/tb_tnoc_output_arbiter.sv
// Bench for tnoc_output_arbiter: an unmasked and a masked (5'b01111) instance
// share stimulus; a cycle model feeds a scoreboard, plus directed constant checks.
module tb_tnoc_output_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = '0;
  logic       avail = 1'b0;
  logic       free = 1'b0;

  logic [4:0] g0, g1;
  logic [2:0] i0, i1;
  logic       b0, b1, e0, e1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tnoc_output_arbiter u_dut (
    .clk(clk), .rst(rst), .i_request(req), .i_output_available(avail), .i_free(free),
    .o_grant(g0), .o_grant_index(i0), .o_busy(b0), .o_protocol_error(e0)
  );

  tnoc_output_arbiter #(.REQUESTS(5), .REQUEST_MASK(5'b01111)) u_dut_m (
    .clk(clk), .rst(rst), .i_request(req), .i_output_available(avail), .i_free(free),
    .o_grant(g1), .o_grant_index(i1), .o_busy(b1), .o_protocol_error(e1)
  );

  typedef struct {
    logic [4:0] g0, g1;
    logic [2:0] i0, i1;
    logic       b0, b1, e0, e1;
  } exp_t;

  exp_t sbq[$];

  // reference model state, index 0 = unmasked, 1 = masked
  bit         m_st[2];
  logic [4:0] m_g[2];
  int         m_i[2];
  int         m_p[2];
  bit         m_e[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [4:0] eff, input int p);
    for (int k = 0; k < 5; k++) begin
      int c;
      c = (p + k) % 5;
      if (eff[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0; m_g[d] = '0; m_i[d] = 0; m_p[d] = 0; m_e[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    logic [4:0] eff;
    int w;
    eff = req & ((d == 0) ? 5'b11111 : 5'b01111);
    if (!m_st[d]) begin
      if (free) m_e[d] = 1;
      w = pick(eff, m_p[d]);
      if (w >= 0 && avail) begin
        m_g[d] = 5'b00001 << w; m_i[d] = w; m_st[d] = 1;
      end else m_g[d] = '0;
    end else if (free) begin
      m_p[d] = (m_i[d] + 1) % 5;
      w = pick(eff, m_p[d]);
      if (w >= 0 && avail) begin
        m_g[d] = 5'b00001 << w; m_i[d] = w;
      end else begin
        m_g[d] = '0; m_st[d] = 0;
      end
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk("grant", 32'(g0), 32'(e.g0));
    chk("index", 32'(i0), 32'(e.i0));
    chk("busy",  32'(b0), 32'(e.b0));
    chk("perr",  32'(e0), 32'(e.e0));
    chk("m_grant", 32'(g1), 32'(e.g1));
    chk("m_index", 32'(i1), 32'(e.i1));
    chk("m_busy",  32'(b1), 32'(e.b1));
    chk("m_perr",  32'(e1), 32'(e.e1));
  endtask

  // inputs are already set; push the expected post-edge state, clock, compare
  task automatic cycle();
    exp_t e;
    model_step(0);
    model_step(1);
    e.g0 = m_g[0]; e.i0 = 3'(m_i[0]); e.b0 = m_st[0]; e.e0 = m_e[0];
    e.g1 = m_g[1]; e.i1 = 3'(m_i[1]); e.b1 = m_st[1]; e.e1 = m_e[1];
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_grant", 32'(g0), 32'd0);
    chk("rst_index", 32'(i0), 32'd0);
    chk("rst_busy",  32'(b0), 32'd0);
    chk("rst_perr",  32'(e0), 32'd0);
    chk("rst_m_grant", 32'(g1), 32'd0);
    chk("rst_m_perr",  32'(e1), 32'd0);
    model_reset();
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int cnt[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: first grant one cycle after request
    req = 5'b10100; avail = 1'b1;
    cycle();
    chk("t1_grant", 32'(g0), 32'b00100);
    chk("t1_index", 32'(i0), 32'd2);
    chk("t1_busy",  32'(b0), 32'd1);

    // 2: back-to-back handover, then wrap to 0
    req = 5'b10101; free = 1'b1;
    cycle();
    chk("t2_grant4", 32'(g0), 32'b10000);
    cycle();
    chk("t2_grant0", 32'(g0), 32'b00001);

    // 3: owner 1 drops its request, grant held
    req = 5'b00010;
    cycle();
    chk("t3_grant1", 32'(g0), 32'b00010);
    free = 1'b0; req = 5'b11101;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("t3_hold", 32'(g0), 32'b00010);
    end

    // 4: masked requester 4 never granted; free in IDLE flags error
    req = 5'b10000; free = 1'b1;
    cycle();
    chk("t4_grant4", 32'(g0), 32'b10000);
    free = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t4_m_grant", 32'(g1), 32'd0);
      chk("t4_m_perr0", 32'(e1), 32'd0);
    end
    free = 1'b1;
    cycle();
    chk("t4_m_perr1", 32'(e1), 32'd1);
    free = 1'b0;
    cycle();
    chk("t4_m_sticky", 32'(e1), 32'd1);

    // 5: availability gating, then reset mid-packet
    req = 5'b00000; free = 1'b1;
    cycle();
    chk("t5_idle", 32'(b0), 32'd0);
    free = 1'b0; req = 5'b01000; avail = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t5_noavail", 32'(g0), 32'd0);
    end
    avail = 1'b1;
    cycle();
    chk("t5_grant3", 32'(g0), 32'b01000);
    chk("t5_index3", 32'(i0), 32'd3);
    free = 1'b1;
    cycle();
    chk("t5_regrant3", 32'(g0), 32'b01000);
    free = 1'b0;
    do_reset();
    req = 5'b10010;
    cycle();
    chk("t5_ptr0", 32'(g0), 32'b00010);

    // 6: rotation under full load, free every 4 cycles
    do_reset();
    req = 5'b11111; avail = 1'b1;
    cycle();
    for (int p = 0; p < 6; p++) begin
      chk("t6_index", 32'(i0), 32'(p % 5));
      chk("t6_grant", 32'(g0), 32'(5'b00001 << (p % 5)));
      if (p < 5) cnt[i0]++;
      for (int k = 0; k < 3; k++) cycle();
      free = 1'b1;
      cycle();
      free = 1'b0;
    end
    for (int r = 0; r < 5; r++) chk("t6_fair", 32'(cnt[r]), 32'd1);

    // random traffic against the model
    for (int k = 0; k < 300; k++) begin
      req   = 5'($urandom);
      avail = ($urandom_range(0, 3) != 0);
      free  = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
